cache_ri: RTL

- Refill/IO responder that sits behind the cache read/write front end and accepts its `ri_cmd` commands.
- For uncached IO commands it performs a single-word access on the m0 memory bus.
- For block-refill commands it fills a whole 16-word line into the 4-way data/tag/dre RAMs, first writing back a dirty victim.
- It returns a one-cycle `ri_cmd_ready` pulse, with `ri_rsp_data` valid in that cycle.

---
 rtl/cache_ri.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_ri.sv
// Refill / uncached-IO responder behind the cache front end: single-word IO on m0,
// 16-word line refill into the 4-way data/tag/dre RAMs with dirty-victim write-back.
module cache_ri #(
   parameter int unsigned SIZE = 8192,
   localparam int unsigned DW   = $clog2(SIZE / 16),
   localparam int unsigned TW   = DW - 4,
   localparam int unsigned RW   = $clog2(SIZE / 32),
   localparam int unsigned TAGW = 32 - (DW + 2)
) (
   input  logic          clk,
   input  logic          rest,
   input  logic [3:0]    ri_cmd,
   input  logic          ri_cmd_valid,
   output logic          ri_cmd_ready,
   output logic [31:0]   ri_rsp_data,
   input  logic [31:0]   ri_address,
   input  logic [3:0]    ri_byteEnable,
   input  logic          ri_write,
   input  logic [31:0]   ri_writeData,
   output logic [31:0]   m0_address,
   output logic [3:0]    m0_byteEnable,
   output logic          m0_read,
   output logic          m0_write,
   output logic [31:0]   m0_writeData,
   input  logic [31:0]   m0_readData,
   input  logic          m0_waitRequest,
   input  logic          m0_readDataValid,
   output logic [DW-1:0] data_ri_readAddress,
   output logic [1:0]    data_ri_rwChannel,
   input  logic [31:0]   data_ri_readData,
   output logic [DW-1:0] data_ri_writeAddress,
   output logic [3:0]    data_ri_writeByteEnable,
   output logic          data_ri_writeEnable,
   output logic [31:0]   data_ri_writeData,
   output logic [TW-1:0] tag_ri_readAddress,
   output logic [1:0]    tag_ri_readChannel,
   input  logic [31:0]   tag_ri_readData,
   output logic [TW-1:0] tag_ri_writeAddress,
   output logic [1:0]    tag_ri_writeChannel,
   output logic          tag_ri_writeEnable,
   output logic [31:0]   tag_ri_writeData,
   input  logic          tag_ri_isHaveFreeBlock,
   input  logic [1:0]    tag_ri_freeBlockNum,
   output logic [RW-1:0] dre_ri_writeAddress,
   output logic [1:0]    dre_ri_writeChannel,
   output logic          dre_ri_writeEnable,
   output logic [7:0]    dre_ri_writeData
);

   typedef enum logic [3:0] {
      StIdle, StIoReq, StIoWait, StTagRd, StTagChk, StWbRd, StWbWr,
      StRfReq, StRfWait, StTagWr, StDone
   } state_e;

   state_e            r_state, w_next;
   logic              r_after_done;
   logic [1:0]        r_rr;
   logic [1:0]        r_way;
   logic [3:0]        r_wc;
   logic [TAGW-1:0]   r_vtag;
   logic [31:0]       r_rsp_data;

   logic [TW-1:0]     w_index;
   logic [1:0]        w_victim;
   logic              w_unused;

   assign w_index     = ri_address[DW+1:6];
   assign w_victim    = tag_ri_isHaveFreeBlock ? tag_ri_freeBlockNum : r_rr;
   assign ri_rsp_data = r_rsp_data;
   assign w_unused    = ^{tag_ri_readData[29:TAGW], ri_address[1:0]};

   always_ff @(posedge clk) begin
      if (rest) r_state <= StIdle;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         r_after_done <= 1'b0;
         r_rr         <= 2'd0;
         r_way        <= 2'd0;
         r_wc         <= 4'd0;
         r_vtag       <= '0;
         r_rsp_data   <= 32'd0;
      end else begin
         // valid is still high in the cycle after ready; ignore it there
         r_after_done <= (r_state == StDone);
         case (r_state)
            StIdle:   r_wc <= 4'd0;
            StIoWait: if (m0_readDataValid) r_rsp_data <= m0_readData;
            StTagRd: begin
               r_way <= w_victim;
               if (!tag_ri_isHaveFreeBlock) r_rr <= r_rr + 2'd1;
            end
            StTagChk: r_vtag <= tag_ri_readData[TAGW-1:0];
            StWbWr:   if (!m0_waitRequest) r_wc <= (r_wc == 4'd15) ? 4'd0 : r_wc + 4'd1;
            StRfWait: if (m0_readDataValid) r_wc <= (r_wc == 4'd15) ? 4'd0 : r_wc + 4'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (ri_cmd_valid && !r_after_done) begin
               case (ri_cmd)
                  4'd1:    w_next = StIoReq;
                  4'd2:    w_next = StTagRd;
                  4'd3:    w_next = StDone;
                  default: w_next = StIdle;
               endcase
            end
         end
         StIoReq:  if (!m0_waitRequest) w_next = ri_write ? StDone : StIoWait;
         StIoWait: if (m0_readDataValid) w_next = StDone;
         StTagRd:  w_next = StTagChk;
         StTagChk: w_next = (tag_ri_readData[31] && tag_ri_readData[30]) ? StWbRd : StRfReq;
         StWbRd:   w_next = StWbWr;
         StWbWr:   if (!m0_waitRequest) w_next = (r_wc == 4'd15) ? StRfReq : StWbRd;
         StRfReq:  if (!m0_waitRequest) w_next = StRfWait;
         StRfWait: if (m0_readDataValid) w_next = (r_wc == 4'd15) ? StTagWr : StRfReq;
         StTagWr:  w_next = StDone;
         StDone:   w_next = StIdle;
         default:  w_next = StIdle;
      endcase
   end

   always_comb begin
      ri_cmd_ready            = 1'b0;
      m0_address              = 32'd0;
      m0_byteEnable           = 4'd0;
      m0_read                 = 1'b0;
      m0_write                = 1'b0;
      m0_writeData            = 32'd0;
      data_ri_readAddress     = '0;
      data_ri_rwChannel       = 2'd0;
      data_ri_writeAddress    = '0;
      data_ri_writeByteEnable = 4'd0;
      data_ri_writeEnable     = 1'b0;
      data_ri_writeData       = 32'd0;
      tag_ri_readAddress      = '0;
      tag_ri_readChannel      = 2'd0;
      tag_ri_writeAddress     = '0;
      tag_ri_writeChannel     = 2'd0;
      tag_ri_writeEnable      = 1'b0;
      tag_ri_writeData        = 32'd0;
      dre_ri_writeAddress     = '0;
      dre_ri_writeChannel     = 2'd0;
      dre_ri_writeEnable      = 1'b0;
      dre_ri_writeData        = 8'd0;
      unique case (r_state)
         StIoReq: begin
            m0_address    = {ri_address[31:2], 2'b00};
            m0_byteEnable = ri_byteEnable;
            m0_write      = ri_write;
            m0_read       = !ri_write;
            m0_writeData  = ri_writeData;
         end
         StTagRd: begin
            tag_ri_readAddress = w_index;
            tag_ri_readChannel = w_victim;
         end
         StTagChk: begin
            tag_ri_readAddress = w_index;
            tag_ri_readChannel = r_way;
         end
         StWbRd: begin
            data_ri_readAddress = {w_index, r_wc};
            data_ri_rwChannel   = r_way;
         end
         StWbWr: begin
            // read address held so the RAM keeps presenting the same word under stall
            data_ri_readAddress = {w_index, r_wc};
            data_ri_rwChannel   = r_way;
            m0_write            = 1'b1;
            m0_address          = {r_vtag, w_index, r_wc, 2'b00};
            m0_byteEnable       = 4'hF;
            m0_writeData        = data_ri_readData;
         end
         StRfReq: begin
            data_ri_rwChannel = r_way;
            m0_read           = 1'b1;
            m0_address        = {ri_address[31:6], r_wc, 2'b00};
            m0_byteEnable     = 4'hF;
         end
         StRfWait: begin
            data_ri_rwChannel = r_way;
            if (m0_readDataValid) begin
               data_ri_writeAddress    = {w_index, r_wc};
               data_ri_writeByteEnable = 4'hF;
               data_ri_writeEnable     = 1'b1;
               data_ri_writeData       = m0_readData;
               if (r_wc[0]) begin
                  dre_ri_writeAddress = {w_index, r_wc[3:1]};
                  dre_ri_writeChannel = r_way;
                  dre_ri_writeEnable  = 1'b1;
                  dre_ri_writeData    = 8'hFF;
               end
            end
         end
         StTagWr: begin
            data_ri_rwChannel   = r_way;
            tag_ri_writeAddress = w_index;
            tag_ri_writeChannel = r_way;
            tag_ri_writeEnable  = 1'b1;
            tag_ri_writeData    = {1'b1, ri_write, {(30 - TAGW){1'b0}}, ri_address[31:DW+2]};
         end
         StDone:  ri_cmd_ready = 1'b1;
         default: ;
      endcase
   end

endmodule
